// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory initiator: size encodings,
// FSM state constants and store lane/mask generation.
package lsu_pkg;

  localparam logic [1:0] SZ_B    = 2'd0;
  localparam logic [1:0] SZ_H    = 2'd1;
  localparam logic [1:0] SZ_W    = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE   = 2'd0;
  localparam lsu_state_t ST_ACCESS = 2'd1;
  localparam lsu_state_t ST_DRAIN  = 2'd2;
  localparam lsu_state_t ST_RESP   = 2'd3;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } lsu_lanes_t;

  // Half accesses snap to addr[1], word accesses always use lane 0.
  function automatic logic [1:0] lsu_eff_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_H:    return {off[1], 1'b0};
      SZ_W:    return 2'b00;
      default: return off;
    endcase
  endfunction

  function automatic lsu_lanes_t lsu_lanes(input logic [1:0] size, input logic [1:0] off,
                                           input logic [31:0] wdata);
    lsu_lanes_t r;
    r = '0;
    case (size)
      SZ_B: begin
        r.mask = 4'b0001 << off;
        r.data = {4{wdata[7:0]}};
      end
      SZ_H: begin
        r.mask = 4'b0011 << off;
        r.data = {2{wdata[15:0]}};
      end
      SZ_W: begin
        r.mask = 4'b1111;
        r.data = wdata;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Load data extraction: shifts the addressed lanes down and applies
// sign or zero extension for byte and half loads.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] sh;

  assign sh = mem_rdata >> {off, 3'b000};

  always_comb begin
    result = '0;
    case (size)
      SZ_B:    result = is_unsigned ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    result = is_unsigned ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      SZ_W:    result = sh;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for the data-memory port: one request at a time,
// store lane alignment, load extension, drain after stores.
// Build option: define LSU_ALIGN_CHECK_EN to report misaligned half/word
// accesses as errors instead of silently aligning them.
//
// state  | meaning
// IDLE   | ready for a request, memory port idle
// ACCESS | single memory cycle driven from latched request
// DRAIN  | wait for the memory to commit a store
// RESP   | response held until WB accepts it
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 1,
  parameter logic [31:0] RESET_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

  lsu_state_t  state;
  logic        we_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic [1:0]  drain_cnt;
  logic [1:0]  off_q;
  logic        req_err;
  logic        access;
  logic [31:0] load_data;
  lsu_lanes_t  lanes;

  assign off_q = lsu_eff_off(size_q, addr_q[1:0]);
  assign lanes = lsu_lanes(size_q, off_q, wdata_q);

`ifdef LSU_ALIGN_CHECK_EN
  assign req_err = (req_size == SZ_RSVD)
                 || ((req_size == SZ_H) && req_addr[0])
                 || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
  assign req_err = (req_size == SZ_RSVD);
`endif

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign access     = (state == ST_ACCESS);

  assign mem_read  = access && !we_q;
  assign mem_write = access && we_q;
  assign mem_addr  = access ? {addr_q[31:2], 2'b00} : RESET_ADDR;
  assign mem_wdata = mem_write ? lanes.data : 32'h0;
  assign mem_mask  = access ? lanes.mask : 4'h0;

  lsu_load_extract u_extract (
    .mem_rdata   (mem_rdata),
    .off         (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SZ_B;
      drain_cnt  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            uns_q      <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            size_q     <= req_size;
            resp_rdata <= '0;
            resp_err   <= req_err;
            state      <= req_err ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (we_q) begin
            drain_cnt <= DRAIN_LOAD;
            state     <= ST_DRAIN;
          end else begin
            resp_rdata <= load_data;
            state      <= ST_RESP;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 2'd0) state <= ST_RESP;
          else                   drain_cnt <= drain_cnt - 2'd1;
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed self-checking bench for lsu_mem_initiator with a small
// byte-masked memory model that commits writes one clock late.
module tb_lsu_mem_initiator;

  localparam int DRAIN = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.DRAIN_CYCLES(DRAIN), .RESET_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata)
  );

  // Memory model: the write sampled at one edge lands at the following edge.
  logic [31:0] mem [0:63];
  logic        pend;
  logic [5:0]  pend_idx;
  logic [31:0] pend_data;
  logic [3:0]  pend_mask;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (pend === 1'b1)
      for (int b = 0; b < 4; b++)
        if (pend_mask[b]) mem[pend_idx][8*b +: 8] <= pend_data[8*b +: 8];
    pend      <= mem_write;
    pend_idx  <= mem_addr[7:2];
    pend_data <= mem_wdata;
    pend_mask <= mem_mask;
  end

  // Issues one request and observes it until the response; returns with the
  // response retired unless hold is set.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input logic hold,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic saw_rd, output logic saw_wr, output logic [3:0] mask,
                        output logic [31:0] maddr, output logic [31:0] mwdata, output int drain);
    int k;
    logic acc;
    lat = -1; rdata = '0; err = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0;
    mask = '0; maddr = '0; mwdata = '0; drain = 0; acc = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns; resp_ready = !hold;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 1;
    while (k <= 20 && lat < 0) begin
      if (mem_read || mem_write) begin
        acc = 1'b1; saw_rd = saw_rd | mem_read; saw_wr = saw_wr | mem_write;
        mask = mem_mask; maddr = mem_addr; mwdata = mem_wdata;
      end else if (resp_valid) begin
        lat = k; rdata = resp_rdata; err = resp_err;
      end else if (acc) begin
        drain++;
      end
      if (lat < 0) begin
        @(posedge clk); #1;
        k++;
      end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL resp_timeout addr=%h got no resp_valid within 20 cycles", addr);
    end else if (!hold) begin
      @(posedge clk); #1;
    end
  endtask

  int lat, drn;
  logic [31:0] rd, ma, mw;
  logic er, srd, swr;
  logic [3:0] mk;

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
    checks++; if ({mem_read, mem_write} !== 2'b00) begin failures++; $display("FAIL rst_mem_en got=%b exp=00", {mem_read, mem_write}); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    checks++; if ({mem_wdata, mem_mask} !== 36'h0) begin failures++; $display("FAIL rst_mem_data got=%h/%h exp=0/0", mem_wdata, mem_mask); end
  endtask

  task automatic test_store_load_word();
    do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b0, lat, rd, er, srd, swr, mk, ma, mw, drn);
    checks++; if (swr !== 1'b1 || srd !== 1'b0) begin failures++; $display("FAIL stw_enables got wr=%b rd=%b exp wr=1 rd=0", swr, srd); end
    checks++; if (mk !== 4'hF) begin failures++; $display("FAIL stw_mask got=%h exp=f", mk); end
    checks++; if (mw !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stw_wdata got=%h exp=deadbeef", mw); end
    checks++; if (ma !== 32'h8000_0010) begin failures++; $display("FAIL stw_addr got=%h exp=80000010", ma); end
    checks++; if (drn !== DRAIN) begin failures++; $display("FAIL stw_drain got=%0d exp=%0d", drn, DRAIN); end
    checks++; if (lat !== 2 + DRAIN) begin failures++; $display("FAIL stw_latency got=%0d exp=%0d", lat, 2 + DRAIN); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL stw_resp got=%h/%b exp=0/0", rd, er); end
    do_req(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0, 1'b0, lat, rd, er, srd, swr, mk, ma, mw, drn);
    checks++; if (srd !== 1'b1 || swr !== 1'b0) begin failures++; $display("FAIL ldw_enables got rd=%b wr=%b exp rd=1 wr=0", srd, swr); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL ldw_latency got=%0d exp=2", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ldw_rdata got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_load_byte();
    do_req(1'b1, 32'h8000_0010, 32'h80FF_0000, 2'd2, 1'b0, 1'b0, lat, rd, er, srd, swr, mk, ma, mw, drn);
    do_req(1'b0, 32'h8000_0013, 32'h0, 2'd0, 1'b0, 1'b0, lat, rd, er, srd, swr, mk, ma, mw, drn);
    checks++; if (mk !== 4'b1000) begin failures++; $display("FAIL lb_mask got=%b exp=1000", mk); end
    checks++; if (rd !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_signed got=%h exp=ffffff80", rd); end
    do_req(1'b0, 32'h8000_0013, 32'h0, 2'd0, 1'b1, 1'b0, lat, rd, er, srd, swr, mk, ma, mw, drn);
    checks++; if (rd !== 32'h0000_0080) begin failures++; $display("FAIL lbu_unsigned got=%h exp=00000080", rd); end
    do_req(1'b0, 32'h8000_0012, 32'h0, 2'd1, 1'b0, 1'b0, lat, rd, er, srd, swr, mk, ma, mw, drn);
    checks++; if (rd !== 32'hFFFF_80FF || mk !== 4'b1100) begin failures++; $display("FAIL lh_signed got=%h/%b exp=ffff80ff/1100", rd, mk); end
  endtask

  task automatic test_store_half();
    do_req(1'b1, 32'h8000_0020, 32'hAAAA_5555, 2'd2, 1'b0, 1'b0, lat, rd, er, srd, swr, mk, ma, mw, drn);
    do_req(1'b1, 32'h8000_0022, 32'hFFFF_1234, 2'd1, 1'b0, 1'b0, lat, rd, er, srd, swr, mk, ma, mw, drn);
    checks++; if (mk !== 4'b1100) begin failures++; $display("FAIL sh_mask got=%b exp=1100", mk); end
    checks++; if (mw !== 32'h1234_1234) begin failures++; $display("FAIL sh_wdata got=%h exp=12341234", mw); end
    checks++; if (ma !== 32'h8000_0020) begin failures++; $display("FAIL sh_addr got=%h exp=80000020", ma); end
    do_req(1'b0, 32'h8000_0020, 32'h0, 2'd2, 1'b0, 1'b0, lat, rd, er, srd, swr, mk, ma, mw, drn);
    checks++; if (rd !== 32'h1234_5555) begin failures++; $display("FAIL sh_readback got=%h exp=12345555", rd); end
  endtask

  task automatic test_misaligned();
    do_req(1'b1, 32'h8000_0000, 32'h0BAD_F00D, 2'd2, 1'b0, 1'b0, lat, rd, er, srd, swr, mk, ma, mw, drn);
    do_req(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0, 1'b0, lat, rd, er, srd, swr, mk, ma, mw, drn);
`ifdef LSU_ALIGN_CHECK_EN
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", er); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL mis_latency got=%0d exp=1", lat); end
    checks++; if (srd !== 1'b0 || swr !== 1'b0) begin failures++; $display("FAIL mis_no_access got rd=%b wr=%b exp 0/0", srd, swr); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mis_rdata got=%h exp=0", rd); end
`else
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL mis_err got=%b exp=0", er); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL mis_latency got=%0d exp=2", lat); end
    checks++; if (ma !== 32'h8000_0000 || mk !== 4'hF) begin failures++; $display("FAIL mis_addr got=%h/%h exp=80000000/f", ma, mk); end
    checks++; if (rd !== 32'h0BAD_F00D) begin failures++; $display("FAIL mis_rdata got=%h exp=0badf00d", rd); end
`endif
    do_req(1'b1, 32'h8000_0010, 32'h1111_2222, 2'd3, 1'b0, 1'b0, lat, rd, er, srd, swr, mk, ma, mw, drn);
    checks++; if (er !== 1'b1 || lat !== 1) begin failures++; $display("FAIL rsvd_err got err=%b lat=%0d exp err=1 lat=1", er, lat); end
    checks++; if (srd !== 1'b0 || swr !== 1'b0) begin failures++; $display("FAIL rsvd_no_access got rd=%b wr=%b exp 0/0", srd, swr); end
  endtask

  task automatic test_hold();
    do_req(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0, 1'b1, lat, rd, er, srd, swr, mk, ma, mw, drn);
    checks++; if (rd !== 32'h80FF_0000) begin failures++; $display("FAIL hold_first got=%h exp=80ff0000", rd); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h80FF_0000 || req_ready !== 1'b0 ||
          mem_read !== 1'b0 || mem_write !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got v=%b d=%h rdy=%b rd=%b wr=%b exp v=1 d=80ff0000 rdy=0 rd=0 wr=0",
                 i, resp_valid, resp_rdata, req_ready, mem_read, mem_write);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL hold_release got rdy=%b v=%b exp 1/0", req_ready, resp_valid); end
  endtask

  task automatic test_reset_drain();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0030; req_wdata = 32'h0000_0055;
    req_size = 2'd2; req_unsigned = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL rd_access got wr=%b exp=1", mem_write); end
    @(posedge clk); #1;
    checks++; if (mem_write !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL rd_in_drain got wr=%b v=%b rdy=%b exp 0/0/0", mem_write, resp_valid, req_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL rd_handshake got rdy=%b v=%b exp 1/0", req_ready, resp_valid); end
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_mask !== 4'h0) begin failures++; $display("FAIL rd_mem_idle got rd=%b wr=%b a=%h d=%h m=%h exp all 0", mem_read, mem_write, mem_addr, mem_wdata, mem_mask); end
    @(negedge clk); rst = 1'b0;
    do_req(1'b0, 32'h8000_0030, 32'h0, 2'd2, 1'b0, 1'b0, lat, rd, er, srd, swr, mk, ma, mw, drn);
    checks++; if (rd !== 32'h0000_0055) begin failures++; $display("FAIL rd_store_kept got=%h exp=00000055", rd); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst = 1'b0;
    test_store_load_word();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_hold();
    test_reset_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
